// File: rtl/renkon_layer_sched_if.sv
// Host/datapath bundle for renkon_layer_sched: config + req/ack on the host side,
// strobes and addresses toward mem_net/linebuf/core/serial. img_stall exists only with RENKON_STALL_EN.
interface renkon_layer_sched_if #(
    parameter int CORE    = 8,
    parameter int LWIDTH  = 10,
    parameter int IMGSIZE = 12,
    parameter int NETSIZE = 11
);
    localparam int CW = $clog2(CORE);

    logic               req;
    logic [LWIDTH-1:0]  total_out;
    logic [LWIDTH-1:0]  total_in;
    logic [LWIDTH-1:0]  img_size;
    logic [LWIDTH-1:0]  fil_size;
    logic [LWIDTH-1:0]  pool_size;
    logic [1:0]         stride;
    logic [IMGSIZE-1:0] in_offset;
    logic [IMGSIZE-1:0] out_offset;
    logic [NETSIZE-1:0] net_offset;
`ifdef RENKON_STALL_EN
    logic               img_stall;
`endif
    logic               ack;
    logic [CORE-1:0]    core_mask;
    logic [NETSIZE-1:0] net_addr;
    logic               wreg_we;
    logic               img_re;
    logic [IMGSIZE-1:0] img_addr;
    logic               conv_first;
    logic               conv_valid;
    logic               bias_oe;
    logic               out_we;
    logic [CW-1:0]      out_core;

    modport master (
`ifdef RENKON_STALL_EN
        output img_stall,
`endif
        output req, total_out, total_in, img_size, fil_size, pool_size, stride,
               in_offset, out_offset, net_offset,
        input  ack, core_mask, net_addr, wreg_we, img_re, img_addr, conv_first,
               conv_valid, bias_oe, out_we, out_core
    );

    modport slave (
`ifdef RENKON_STALL_EN
        input  img_stall,
`endif
        input  req, total_out, total_in, img_size, fil_size, pool_size, stride,
               in_offset, out_offset, net_offset,
        output ack, core_mask, net_addr, wreg_we, img_re, img_addr, conv_first,
               conv_valid, bias_oe, out_we, out_core
    );
endinterface

// File: rtl/renkon_layer_sched.sv
// Layer sequencer: groups of CORE output channels, per input channel load weights + scan image,
// then bias and serial write-back. Optional RENKON_STALL_EN adds the img_stall counter freeze.
module renkon_layer_sched #(
    parameter int CORE    = 8,
    parameter int LWIDTH  = 10,
    parameter int IMGSIZE = 12,
    parameter int NETSIZE = 11
) (
    input  logic                 clk,
    input  logic                 xrst,
    renkon_layer_sched_if.slave  bus
);
    localparam int CW = $clog2(CORE);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LOAD, S_SCAN, S_BIAS, S_OUT, S_DONE} state_t;

    state_t             r_state;
    logic               r_ack, r_wreg_we, r_img_re, r_conv_first, r_conv_valid, r_bias_oe, r_out_we, r_s2;
    logic [CORE-1:0]    r_core_mask;
    logic [NETSIZE-1:0] r_net_addr;
    logic [IMGSIZE-1:0] r_img_addr, r_saddr, r_oaddr, r_in_off;
    logic [LWIDTH-1:0]  r_tin, r_img_m1, r_fil_m1, r_pout, r_rem, r_i;
    logic [LWIDTH-1:0]  r_kx, r_ky, r_sx, r_sy, r_px, r_py;
    logic [CW-1:0]      r_c;

    logic [LWIDTH-1:0]  w_fea, w_pout, w_sx_nxt, w_sy_nxt, w_rem_nxt;
    logic               w_k_end, w_sx_end, w_s_end, w_px_end, w_p_end, w_last_grp, w_c_end, w_stall;

    function automatic logic win_f(input logic [LWIDTH-1:0] x, input logic [LWIDTH-1:0] y,
                                   input logic [LWIDTH-1:0] fm1, input logic s2);
        logic [LWIDTH-1:0] dx, dy;
        dx = x - fm1;
        dy = y - fm1;
        win_f = (x >= fm1) && (y >= fm1) && (!s2 || (!dx[0] && !dy[0]));
    endfunction

    function automatic logic [CORE-1:0] mask_f(input logic [LWIDTH-1:0] rem);
        logic [CORE:0] one_hot;
        one_hot = {{CORE{1'b0}}, 1'b1} << rem;
        mask_f  = (rem >= LWIDTH'(CORE)) ? {CORE{1'b1}} : CORE'(one_hot - 1'b1);
    endfunction

    assign w_fea      = ((bus.img_size - bus.fil_size) >> (bus.stride == 2'd2)) + 1'b1;
    assign w_pout     = (bus.pool_size == LWIDTH'(2)) ? (w_fea >> 1) : w_fea;
    assign w_k_end    = (r_kx == r_fil_m1) && (r_ky == r_fil_m1);
    assign w_sx_end   = (r_sx == r_img_m1);
    assign w_s_end    = w_sx_end && (r_sy == r_img_m1);
    assign w_sx_nxt   = w_sx_end ? '0 : r_sx + 1'b1;
    assign w_sy_nxt   = w_sx_end ? r_sy + 1'b1 : r_sy;
    assign w_px_end   = (r_px == r_pout - 1'b1);
    assign w_p_end    = (w_px_end && (r_py == r_pout - 1'b1)) || (r_pout == '0);
    // r_rem tracks total_out - g*CORE, so the last group is the one with at most CORE left
    assign w_last_grp = (r_rem <= LWIDTH'(CORE));
    assign w_c_end    = w_last_grp ? (LWIDTH'(r_c) == r_rem - 1'b1) : (r_c == CW'(CORE - 1));
    assign w_rem_nxt  = r_rem - LWIDTH'(CORE);

`ifdef RENKON_STALL_EN
    assign w_stall = bus.img_stall && (r_state == S_LOAD || r_state == S_SCAN || r_state == S_OUT);
`else
    assign w_stall = 1'b0;
`endif

    always_ff @(posedge clk or posedge xrst) begin
        if (xrst) begin
            r_state <= S_IDLE;   r_ack <= 1'b1;        r_core_mask <= '0;
            r_wreg_we <= 1'b0;   r_img_re <= 1'b0;     r_conv_first <= 1'b0;
            r_conv_valid <= 1'b0; r_bias_oe <= 1'b0;   r_out_we <= 1'b0;
            r_net_addr <= '0;    r_img_addr <= '0;     r_saddr <= '0;
            r_oaddr <= '0;       r_in_off <= '0;       r_s2 <= 1'b0;
            r_tin <= '0;         r_img_m1 <= '0;       r_fil_m1 <= '0;
            r_pout <= '0;        r_rem <= '0;          r_i <= '0;
            r_kx <= '0;          r_ky <= '0;           r_sx <= '0;
            r_sy <= '0;          r_px <= '0;           r_py <= '0;
            r_c <= '0;
        end else begin
            case (r_state)
                S_IDLE: if (bus.req) begin
                    r_state <= S_SETUP;
                    r_ack   <= 1'b0;
                end
                S_SETUP: begin
                    r_tin      <= bus.total_in;
                    r_img_m1   <= bus.img_size - 1'b1;
                    r_fil_m1   <= bus.fil_size - 1'b1;
                    r_s2       <= (bus.stride == 2'd2);
                    r_pout     <= w_pout;
                    r_rem      <= bus.total_out;
                    r_in_off   <= bus.in_offset;
                    r_saddr    <= bus.in_offset;
                    r_oaddr    <= bus.out_offset;
                    r_net_addr <= bus.net_offset;
                    r_i <= '0; r_kx <= '0; r_ky <= '0;
                    if (bus.total_out == '0 || bus.total_in == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_state     <= S_LOAD;
                        r_wreg_we   <= 1'b1;
                        r_core_mask <= mask_f(bus.total_out);
                    end
                end
                // weights are contiguous across channels and groups, so net_addr just runs
                S_LOAD: if (!w_stall) begin
                    r_net_addr <= r_net_addr + 1'b1;
                    if (w_k_end) begin
                        r_state      <= S_SCAN;
                        r_wreg_we    <= 1'b0;
                        r_img_re     <= 1'b1;
                        r_sx <= '0; r_sy <= '0;
                        r_img_addr   <= r_saddr;
                        r_conv_first <= (r_i == '0);
                        r_conv_valid <= win_f('0, '0, r_fil_m1, r_s2);
                    end else begin
                        r_kx <= (r_kx == r_fil_m1) ? '0 : r_kx + 1'b1;
                        r_ky <= (r_kx == r_fil_m1) ? r_ky + 1'b1 : r_ky;
                    end
                end
                S_SCAN: if (!w_stall) begin
                    r_img_addr <= r_img_addr + 1'b1;
                    if (w_s_end) begin
                        r_saddr      <= r_img_addr + 1'b1;
                        r_img_re     <= 1'b0;
                        r_conv_valid <= 1'b0;
                        r_conv_first <= 1'b0;
                        if (r_i == r_tin - 1'b1) begin
                            r_state   <= S_BIAS;
                            r_bias_oe <= 1'b1;
                        end else begin
                            r_state   <= S_LOAD;
                            r_i       <= r_i + 1'b1;
                            r_kx <= '0; r_ky <= '0;
                            r_wreg_we <= 1'b1;
                        end
                    end else begin
                        r_sx         <= w_sx_nxt;
                        r_sy         <= w_sy_nxt;
                        r_conv_valid <= win_f(w_sx_nxt, w_sy_nxt, r_fil_m1, r_s2);
                    end
                end
                S_BIAS: begin
                    r_bias_oe  <= 1'b0;
                    r_state    <= S_OUT;
                    r_out_we   <= (r_pout != '0);
                    r_c <= '0; r_px <= '0; r_py <= '0;
                    r_img_addr <= r_oaddr;
                end
                S_OUT: if (!w_stall) begin
                    if (w_p_end && w_c_end) begin
                        r_out_we <= 1'b0;
                        r_oaddr  <= r_out_we ? r_img_addr + 1'b1 : r_img_addr;
                        if (w_last_grp) begin
                            r_state <= S_DONE;
                        end else begin
                            r_state     <= S_LOAD;
                            r_rem       <= w_rem_nxt;
                            r_core_mask <= mask_f(w_rem_nxt);
                            r_i <= '0; r_kx <= '0; r_ky <= '0;
                            r_saddr     <= r_in_off;
                            r_wreg_we   <= 1'b1;
                        end
                    end else if (w_p_end) begin
                        r_c <= r_c + 1'b1;
                        r_px <= '0; r_py <= '0;
                        r_img_addr <= r_img_addr + 1'b1;
                    end else begin
                        r_px <= w_px_end ? '0 : r_px + 1'b1;
                        r_py <= w_px_end ? r_py + 1'b1 : r_py;
                        r_img_addr <= r_img_addr + 1'b1;
                    end
                end
                S_DONE: begin
                    r_ack   <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.ack        = r_ack;
    assign bus.core_mask  = r_core_mask;
    assign bus.net_addr   = r_net_addr;
    assign bus.img_addr   = r_img_addr;
    assign bus.conv_first = r_conv_first;
    assign bus.bias_oe    = r_bias_oe;
    assign bus.out_core   = r_c;
    assign bus.wreg_we    = r_wreg_we    & ~w_stall;
    assign bus.img_re     = r_img_re     & ~w_stall;
    assign bus.conv_valid = r_conv_valid & ~w_stall;
    assign bus.out_we     = r_out_we     & ~w_stall;
endmodule

// File: tb/tb_renkon_layer_sched.sv
// Scoreboard bench for renkon_layer_sched: a reference model queues every expected strobe event,
// a monitor pops one per strobed cycle; hand-computed cycle/strobe counts are checked per run.
module tb_renkon_layer_sched;
    localparam int CORE = 8, LWIDTH = 10, IMGSIZE = 12, NETSIZE = 11;

    logic clk = 1'b0;
    logic xrst = 1'b1;
    always #5 clk = ~clk;

    renkon_layer_sched_if #(.CORE(CORE), .LWIDTH(LWIDTH), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE)) bus();
    renkon_layer_sched #(.CORE(CORE), .LWIDTH(LWIDTH), .IMGSIZE(IMGSIZE), .NETSIZE(NETSIZE))
        dut (.clk(clk), .xrst(xrst), .bus(bus));

    typedef struct packed {
        logic [1:0]  kind;   // 0 load, 1 scan, 2 bias, 3 out
        logic [15:0] addr;
        logic [7:0]  mask;
        logic        first;
        logic        valid;
        logic [2:0]  core;
    } ev_t;

    ev_t exp_q[$];
    int n_vec = 0, n_err = 0;
    int n_ld = 0, n_sc = 0, n_bi = 0, n_ou = 0, n_cv = 0;
    int b_ld, b_sc, b_bi, b_ou, b_cv;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_model(input int tout, input int tin, input int img, input int fil,
                              input int pool, input int stride, input int inoff,
                              input int outoff, input int netoff);
        int fea, pout, nv;
        logic [7:0] m;
        ev_t e;
        if (tout == 0 || tin == 0) return;
        fea  = ((img - fil) >> (stride - 1)) + 1;
        pout = fea >> (pool - 1);
        for (int g = 0; g * CORE < tout; g++) begin
            nv = (tout - g * CORE >= CORE) ? CORE : tout - g * CORE;
            m  = (nv == CORE) ? 8'hFF : 8'((1 << nv) - 1);
            for (int i = 0; i < tin; i++) begin
                for (int k = 0; k < fil * fil; k++) begin
                    e = '0; e.kind = 2'd0; e.mask = m;
                    e.addr = 16'((netoff + (g * tin + i) * fil * fil + k) % 2048);
                    exp_q.push_back(e);
                end
                for (int y = 0; y < img; y++)
                    for (int x = 0; x < img; x++) begin
                        e = '0; e.kind = 2'd1; e.mask = m; e.first = (i == 0);
                        e.addr  = 16'((inoff + i * img * img + y * img + x) % 4096);
                        e.valid = (y >= fil - 1) && (x >= fil - 1) &&
                                  (stride == 1 || (((x - fil + 1) % 2 == 0) && ((y - fil + 1) % 2 == 0)));
                        exp_q.push_back(e);
                    end
            end
            e = '0; e.kind = 2'd2; e.mask = m;
            exp_q.push_back(e);
            for (int c = 0; c < nv; c++)
                for (int p = 0; p < pout * pout; p++) begin
                    e = '0; e.kind = 2'd3; e.mask = m; e.core = 3'(c);
                    e.addr = 16'((outoff + (g * CORE + c) * pout * pout + p) % 4096);
                    exp_q.push_back(e);
                end
        end
    endtask

    task automatic start(input int tout, input int tin, input int img, input int fil,
                         input int pool, input int stride, input int inoff,
                         input int outoff, input int netoff);
        bus.total_out  = LWIDTH'(tout);  bus.total_in  = LWIDTH'(tin);
        bus.img_size   = LWIDTH'(img);   bus.fil_size  = LWIDTH'(fil);
        bus.pool_size  = LWIDTH'(pool);  bus.stride    = 2'(stride);
        bus.in_offset  = IMGSIZE'(inoff); bus.out_offset = IMGSIZE'(outoff);
        bus.net_offset = NETSIZE'(netoff);
        push_model(tout, tin, img, fil, pool, stride, inoff, outoff, netoff);
        b_ld = n_ld; b_sc = n_sc; b_bi = n_bi; b_ou = n_ou; b_cv = n_cv;
        @(posedge clk); #1 bus.req = 1'b1;
        @(posedge clk); #1 bus.req = 1'b0;
    endtask

    // exp_lc < 0 skips the ack-low cycle count (stalled runs)
    task automatic wait_done(input string name, input int exp_lc, input bit busy_req,
                             input int e_ld, input int e_sc, input int e_bi, input int e_ou, input int e_cv);
        int lc;
        lc = 0;
        while (!bus.ack && lc < 2000) begin
            lc++;
            bus.req = (busy_req && lc == 10);
            @(posedge clk); #1;
        end
        bus.req = 1'b0;
        if (lc >= 2000) chk({name, " ack timeout"}, lc, -1);
        if (exp_lc >= 0) chk({name, " ack-low cycles"}, lc, exp_lc);
        repeat (4) @(posedge clk);
        #1;
        chk({name, " ack idle"}, int'(bus.ack), 1);
        chk({name, " queue left"}, exp_q.size(), 0);
        chk({name, " wreg_we"}, n_ld - b_ld, e_ld);
        chk({name, " img_re"}, n_sc - b_sc, e_sc);
        chk({name, " bias_oe"}, n_bi - b_bi, e_bi);
        chk({name, " out_we"}, n_ou - b_ou, e_ou);
        chk({name, " conv_valid"}, n_cv - b_cv, e_cv);
        exp_q.delete();
    endtask

    task automatic chk_reset(input string name);
        chk({name, " ack"}, int'(bus.ack), 1);
        chk({name, " strobes"}, int'({bus.wreg_we, bus.img_re, bus.bias_oe, bus.out_we, bus.conv_valid}), 0);
        chk({name, " core_mask"}, int'(bus.core_mask), 0);
        chk({name, " addrs"}, int'(bus.net_addr) + int'(bus.img_addr), 0);
    endtask

    initial begin
        bus.req = 1'b0; bus.total_out = '0; bus.total_in = '0; bus.img_size = '0;
        bus.fil_size = '0; bus.pool_size = '0; bus.stride = '0;
        bus.in_offset = '0; bus.out_offset = '0; bus.net_offset = '0;
`ifdef RENKON_STALL_EN
        bus.img_stall = 1'b0;
`endif
        fork
            forever begin
                ev_t a, e;
                @(negedge clk);
                if (!xrst && (bus.wreg_we || bus.img_re || bus.bias_oe || bus.out_we)) begin
                    a = '0;
                    if (bus.wreg_we) begin
                        a.kind = 2'd0; a.addr = 16'(bus.net_addr); n_ld++;
                    end else if (bus.img_re) begin
                        a.kind = 2'd1; a.addr = 16'(bus.img_addr);
                        a.first = bus.conv_first; a.valid = bus.conv_valid;
                        n_sc++; if (bus.conv_valid) n_cv++;
                    end else if (bus.bias_oe) begin
                        a.kind = 2'd2; n_bi++;
                    end else begin
                        a.kind = 2'd3; a.addr = 16'(bus.img_addr); a.core = 3'(bus.out_core); n_ou++;
                    end
                    a.mask = bus.core_mask;
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected strobe: got kind=%0d addr=%0h, expected no event", a.kind, a.addr);
                    end else begin
                        e = exp_q.pop_front();
                        if (a !== e) begin
                            n_err++;
                            $display("FAIL event kind=%0d: got addr=%0h mask=%h first=%b valid=%b core=%0d, expected kind=%0d addr=%0h mask=%h first=%b valid=%b core=%0d",
                                     a.kind, a.addr, a.mask, a.first, a.valid, a.core,
                                     e.kind, e.addr, e.mask, e.first, e.valid, e.core);
                        end
                    end
                end
            end
        join_none

        repeat (3) @(posedge clk);
        #1 chk_reset("reset hold");
        xrst = 1'b0;
        @(posedge clk); #1 chk_reset("after release");

        // 9 load + 16 scan + 1 bias + 32 out, plus SETUP and DONE: 60 cycles with ack low
        start(8, 1, 4, 3, 1, 1, 100, 500, 20);
        wait_done("t1 basic", 60, 1'b0, 9, 16, 1, 32, 4);

        // two groups, second masked to 8'h03; weight addresses wrap past 2047
        start(10, 1, 4, 3, 1, 1, 0, 1000, 2040);
        wait_done("t2 partial", 94, 1'b0, 18, 32, 2, 40, 8);

        // stride 2 / pool 2: 9 valid windows per channel, input base wraps past 4095
        start(2, 2, 6, 2, 2, 2, 4090, 7, 3);
        wait_done("t3 stride2", 85, 1'b0, 8, 72, 1, 2, 18);

        start(8, 0, 4, 3, 1, 1, 0, 0, 0);
        wait_done("t4 tin0", 2, 1'b0, 0, 0, 0, 0, 0);
        start(0, 3, 4, 3, 1, 1, 0, 0, 0);
        wait_done("t4 tout0", 2, 1'b0, 0, 0, 0, 0, 0);
        start(8, 1, 4, 3, 1, 1, 100, 500, 20);
        wait_done("t4 busy req", 60, 1'b1, 9, 16, 1, 32, 4);

        start(8, 1, 4, 3, 1, 1, 100, 500, 20);
        repeat (14) @(posedge clk);
        #1 chk("t5 in scan", int'(bus.img_re), 1);
        xrst = 1'b1;
        #1 chk_reset("t5 mid reset");
        exp_q.delete();
        @(posedge clk); #1 xrst = 1'b0;
        start(8, 1, 4, 3, 1, 1, 100, 500, 20);
        wait_done("t5 rerun", 60, 1'b0, 9, 16, 1, 32, 4);

`ifdef RENKON_STALL_EN
        begin
            int hold;
            start(8, 1, 4, 3, 1, 1, 100, 500, 20);
            repeat (14) @(posedge clk);
            #1 hold = int'(bus.img_addr);
            bus.img_stall = 1'b1;
            for (int j = 0; j < 3; j++) begin
                #2;
                chk("t6 stall img_re", int'(bus.img_re), 0);
                chk("t6 stall addr", int'(bus.img_addr), hold);
                @(posedge clk); #1;
            end
            bus.img_stall = 1'b0;
            #1 chk("t6 resume addr", int'(bus.img_addr), hold);
            wait_done("t6 stall", -1, 1'b0, 9, 16, 1, 32, 4);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
